// File: rtl/nibble_deser_pkg.sv
// Shared types and helpers for the nibble deserializer.
// Holds the nibble width, bit-count width, FSM state encoding and bit-level helpers.
package nibble_deser_pkg;

  localparam int NIBBLE_W = 4;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Insert one serial bit so the first bit of a frame ends in bit 3 (msb_first) or bit 0.
  function automatic logic [NIBBLE_W-1:0] shift_bit(input logic [NIBBLE_W-1:0] cur,
                                                    input logic               b,
                                                    input logic               msb_first);
    if (msb_first) begin
      return {cur[NIBBLE_W-2:0], b};
    end else begin
      return {b, cur[NIBBLE_W-1:1]};
    end
  endfunction

  // Even-parity bit: makes the total count of ones over data plus parity even.
  function automatic logic even_par(input logic [NIBBLE_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nibble_deser.sv
// Serial-to-nibble deserializer with START framing and a one-cycle LOAD strobe.
// Define NIBBLE_DESER_PARITY_EN to add a trailing even-parity bit check (PAR state, ERR strobe).
module nibble_deser
  import nibble_deser_pkg::*;
#(
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                SVALID,
  input  logic                SIN,
  output logic [NIBBLE_W-1:0] D_OUT,
  output logic                LOAD,
  output logic                BUSY,
  output logic                ERR
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLE_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIBBLE_W);

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [NIBBLE_W-1:0] shreg_r;
  logic [NIBBLE_W-1:0] shift_nxt_s;

  // Shift register contents if the current SIN bit is accepted this cycle.
  always_comb begin
    shift_nxt_s = shift_bit(shreg_r, SIN, MSB_FIRST);
  end

  // Frame FSM, shift register and registered outputs; strobes default low every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      shreg_r <= {NIBBLE_W{1'b0}};
      D_OUT   <= {NIBBLE_W{1'b0}};
      LOAD    <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      LOAD <= 1'b0;
      ERR  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            state_r <= SHIFT;
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {NIBBLE_W{1'b0}};
            BUSY    <= 1'b1;
          end
        end
        SHIFT: begin
          // START outranks a simultaneous data bit: the partial frame is dropped.
          if (START) begin
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {NIBBLE_W{1'b0}};
          end else if (SVALID) begin
            shreg_r <= shift_nxt_s;
            if (cnt_r == CNT_LAST) begin
              cnt_r <= CNT_FULL;
`ifdef NIBBLE_DESER_PARITY_EN
              state_r <= PAR;
`else
              state_r <= DONE;
              D_OUT   <= shift_nxt_s;
              LOAD    <= 1'b1;
              BUSY    <= 1'b0;
`endif
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
`ifdef NIBBLE_DESER_PARITY_EN
        PAR: begin
          if (START) begin
            state_r <= SHIFT;
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {NIBBLE_W{1'b0}};
          end else if (SVALID) begin
            BUSY <= 1'b0;
            if (SIN == even_par(shreg_r)) begin
              state_r <= DONE;
              D_OUT   <= shreg_r;
              LOAD    <= 1'b1;
            end else begin
              state_r <= IDLE;
              ERR     <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (START) begin
            state_r <= SHIFT;
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= {NIBBLE_W{1'b0}};
            BUSY    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_deser.sv
// Self-checking bench for nibble_deser: directed frames plus randomized traffic against a queue-based model.
// Two instances (MSB_FIRST=1 and MSB_FIRST=0) share the same inputs.
module tb_nibble_deser;

`ifdef NIBBLE_DESER_PARITY_EN
  localparam int FRAME_LEN = 5;
  localparam bit PAR_EN    = 1'b1;
`else
  localparam int FRAME_LEN = 4;
  localparam bit PAR_EN    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       svalid = 1'b0;
  logic       sin = 1'b0;
  logic [3:0] dout_a, dout_b;
  logic       load_a, load_b, busy_a, busy_b, err_a, err_b;

  int n_vec  = 0;
  int n_miss = 0;
  int load_cnt = 0;
  int err_cnt  = 0;

  // Reference model state: bits collected since the last START.
  bit         m_active, m_done, m_load, m_err, m_busy;
  int         q[$];
  logic [3:0] m_dout_a, m_dout_b;

  nibble_deser #(.MSB_FIRST(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .SVALID(svalid), .SIN(sin),
    .D_OUT(dout_a), .LOAD(load_a), .BUSY(busy_a), .ERR(err_a)
  );

  nibble_deser #(.MSB_FIRST(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .SVALID(svalid), .SIN(sin),
    .D_OUT(dout_b), .LOAD(load_b), .BUSY(busy_b), .ERR(err_b)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 1'b0; m_done = 1'b0; m_load = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    q.delete();
    m_dout_a = 4'd0; m_dout_b = 4'd0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit b);
    bit was_done;
    int na, nb, ones;
    bit parity_ok;
    was_done = m_done;
    m_load = 1'b0; m_err = 1'b0; m_done = 1'b0;
    if (was_done) begin
      m_active = s;
      if (s) q.delete();
    end else if (s) begin
      m_active = 1'b1;
      q.delete();
    end else if (m_active && v) begin
      q.push_back(int'(b));
      if (q.size() == FRAME_LEN) begin
        na = 0; nb = 0; ones = 0;
        for (int i = 0; i < 4; i++) begin
          na   = na * 2 + q[i];
          nb   = nb + q[i] * (1 << i);
          ones = ones + q[i];
        end
        parity_ok = 1'b1;
        if (PAR_EN) parity_ok = (q[FRAME_LEN-1] == (ones % 2));
        m_active = 1'b0;
        if (parity_ok) begin
          m_load = 1'b1; m_done = 1'b1;
          m_dout_a = na[3:0]; m_dout_b = nb[3:0];
        end else begin
          m_err = 1'b1;
        end
      end
    end
    m_busy = m_active;
  endtask

  task automatic drive(input bit s, input bit v, input bit b);
    start = s; svalid = v; sin = b;
    @(posedge clk);
    model_step(s, v, b);
    #1;
    if (load_a) load_cnt++;
    if (err_a) err_cnt++;
  endtask

  // Send n bits, bits[n-1] first, with gap idle cycles between consecutive bits.
  task automatic send(input logic [7:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i]);
      if (i > 0) repeat (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (dout_a !== 4'b0000 || dout_b !== 4'b0000) begin n_miss++; $display("FAIL reset_dout: got %b/%b want 0000/0000", dout_a, dout_b); end
    n_vec++; if ({load_a, busy_a, err_a, load_b, busy_b, err_b} !== 6'b000000) begin n_miss++; $display("FAIL reset_flags: got %b want 000000", {load_a, busy_a, err_a, load_b, busy_b, err_b}); end
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b1, 1'b1);
    n_vec++; if (busy_a !== 1'b0 || load_a !== 1'b0) begin n_miss++; $display("FAIL idle_ignores_bit: busy %b load %b want 0 0", busy_a, load_a); end
  endtask

  task automatic test_basic();
    load_cnt = 0;
    drive(1'b1, 1'b1, 1'b0);
    n_vec++; if (busy_a !== 1'b1) begin n_miss++; $display("FAIL busy_after_start: got %b want 1", busy_a); end
    send(8'b1011, 4, 0);
    if (PAR_EN) drive(1'b0, 1'b1, 1'b1);
    n_vec++; if (load_a !== 1'b1 || load_b !== 1'b1) begin n_miss++; $display("FAIL basic_load: got %b/%b want 1/1", load_a, load_b); end
    n_vec++; if (dout_a !== 4'b1011) begin n_miss++; $display("FAIL msb_first_dout: got %b want 1011", dout_a); end
    n_vec++; if (dout_b !== 4'b1101) begin n_miss++; $display("FAIL lsb_first_dout: got %b want 1101", dout_b); end
    n_vec++; if (busy_a !== 1'b0) begin n_miss++; $display("FAIL busy_in_done: got %b want 0", busy_a); end
    drive(1'b0, 1'b0, 1'b0);
    n_vec++; if (load_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 4'b1011) begin n_miss++; $display("FAIL after_done: load %b busy %b dout %b want 0 0 1011", load_a, busy_a, dout_a); end
  endtask

  task automatic test_gaps();
    load_cnt = 0;
    drive(1'b1, 1'b0, 1'b0);
    send(8'b0110, 4, 2);
    if (PAR_EN) begin
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    n_vec++; if (load_cnt !== 1) begin n_miss++; $display("FAIL gaps_load_count: got %0d want 1", load_cnt); end
    n_vec++; if (dout_a !== 4'b0110 || dout_b !== 4'b0110) begin n_miss++; $display("FAIL gaps_dout: got %b/%b want 0110/0110", dout_a, dout_b); end
  endtask

  task automatic test_restart();
    load_cnt = 0;
    drive(1'b1, 1'b0, 1'b0);
    send(8'b10, 2, 0);
    drive(1'b1, 1'b1, 1'b0);
    send(8'b1111, 4, 0);
    if (PAR_EN) drive(1'b0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    n_vec++; if (load_cnt !== 1) begin n_miss++; $display("FAIL restart_load_count: got %0d want 1", load_cnt); end
    n_vec++; if (dout_a !== 4'b1111 || dout_b !== 4'b1111) begin n_miss++; $display("FAIL restart_dout: got %b/%b want 1111/1111", dout_a, dout_b); end
  endtask

  task automatic test_parity();
`ifdef NIBBLE_DESER_PARITY_EN
    load_cnt = 0; err_cnt = 0;
    drive(1'b1, 1'b0, 1'b0);
    send(8'b1011, 4, 0);
    drive(1'b0, 1'b1, 1'b0);
    n_vec++; if (err_a !== 1'b1 || load_a !== 1'b0) begin n_miss++; $display("FAIL par_bad_strobe: err %b load %b want 1 0", err_a, load_a); end
    n_vec++; if (dout_a !== 4'b1111) begin n_miss++; $display("FAIL par_bad_dout_held: got %b want 1111", dout_a); end
    drive(1'b0, 1'b0, 1'b0);
    n_vec++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin n_miss++; $display("FAIL par_err_one_cycle: err %b busy %b want 0 0", err_a, busy_a); end
    drive(1'b1, 1'b0, 1'b0);
    send(8'b1011, 4, 0);
    n_vec++; if (busy_a !== 1'b1 || load_a !== 1'b0) begin n_miss++; $display("FAIL par_wait_state: busy %b load %b want 1 0", busy_a, load_a); end
    drive(1'b0, 1'b1, 1'b1);
    n_vec++; if (load_a !== 1'b1 || err_a !== 1'b0 || dout_a !== 4'b1011) begin n_miss++; $display("FAIL par_good: load %b err %b dout %b want 1 0 1011", load_a, err_a, dout_a); end
    n_vec++; if (load_cnt !== 1 || err_cnt !== 1) begin n_miss++; $display("FAIL par_counts: loads %0d errs %0d want 1 1", load_cnt, err_cnt); end
`else
    err_cnt = 0;
    drive(1'b1, 1'b0, 1'b0);
    send(8'b1011, 4, 0);
    drive(1'b0, 1'b1, 1'b0);
    n_vec++; if (err_cnt !== 0) begin n_miss++; $display("FAIL err_tied_low: got %0d strobes want 0", err_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    load_cnt = 0;
    drive(1'b1, 1'b0, 1'b0);
    send(8'b110, 3, 0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_vec++; if (dout_a !== 4'b0000 || busy_a !== 1'b0 || load_a !== 1'b0 || err_a !== 1'b0) begin n_miss++; $display("FAIL async_reset: dout %b busy %b load %b err %b want 0000 0 0 0", dout_a, busy_a, load_a, err_a); end
    #1 rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    n_vec++; if (busy_a !== 1'b0 || load_cnt !== 0) begin n_miss++; $display("FAIL needs_new_start: busy %b loads %0d want 0 0", busy_a, load_cnt); end
    drive(1'b1, 1'b0, 1'b0);
    send(8'b0101, 4, 0);
    if (PAR_EN) drive(1'b0, 1'b1, 1'b0);
    n_vec++; if (load_a !== 1'b1 || dout_a !== 4'b0101 || dout_b !== 4'b1010) begin n_miss++; $display("FAIL post_reset_frame: load %b dout %b/%b want 1 0101/1010", load_a, dout_a, dout_b); end
  endtask

  task automatic test_random();
    bit s, v, b;
    for (int k = 0; k < 500; k++) begin
      s = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 2) != 0);
      b = $urandom_range(0, 1);
      drive(s, v, b);
      n_vec++; if (load_a !== m_load || load_b !== m_load) begin n_miss++; $display("FAIL rnd_load cyc %0d: got %b/%b want %b", k, load_a, load_b, m_load); end
      n_vec++; if (dout_a !== m_dout_a || dout_b !== m_dout_b) begin n_miss++; $display("FAIL rnd_dout cyc %0d: got %b/%b want %b/%b", k, dout_a, dout_b, m_dout_a, m_dout_b); end
      n_vec++; if (busy_a !== m_busy || busy_b !== m_busy) begin n_miss++; $display("FAIL rnd_busy cyc %0d: got %b/%b want %b", k, busy_a, busy_b, m_busy); end
      n_vec++; if (err_a !== m_err || err_b !== m_err) begin n_miss++; $display("FAIL rnd_err cyc %0d: got %b/%b want %b", k, err_a, err_b, m_err); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_parity();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nibble_deser.md
NIBBLE_DESER -- requirements
Module: nibble_deser

Interface
REQ-001 SHALL have parameter: MSB_FIRST, 1, 1 = first received bit lands in D_OUT[3]; 0 = first bit lands in D_OUT[0].
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: START  input  1  frame-start pulse; begins a new nibble.
REQ-005 SHALL have port: SVALID  input  1  SIN carries a valid bit this cycle.
REQ-006 SHALL have port: SIN  input  1  serial data bit.
REQ-007 SHALL have port: D_OUT  output  4  last completed nibble; drives the downstream 4-bit register data input.
REQ-008 SHALL have port: LOAD  output  1  one-cycle strobe; D_OUT is new and valid.
REQ-009 SHALL have port: BUSY  output  1  a frame is in progress.
REQ-010 SHALL have port: ERR  output  1  one-cycle parity-error strobe; tied 0 when parity is compiled out.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PAR, DONE.
REQ-012 IDLE: START=1 -> SHIFT, bit count cleared to 0, shift register cleared; SVALID and SIN ignored.
REQ-013 SHIFT: each cycle with SVALID=1 shifts SIN in per MSB_FIRST and increments the count; cycles with SVALID=0 hold state.
REQ-014 SHIFT: acceptance of the 4th bit (count 3 -> 4) SHALL go to PAR when parity is enabled, else to DONE.
REQ-015 PAR: next SVALID=1 bit is the even-parity bit over the 4 data bits; match -> DONE; mismatch -> ERR=1 for one cycle, D_OUT unchanged, no LOAD, -> IDLE.
REQ-016 DONE: D_OUT <= assembled nibble and LOAD=1 for exactly one cycle; next state IDLE.
REQ-017 Latency: LOAD SHALL be high in the cycle after the rising edge that accepts the last bit (data or parity).
REQ-018 D_OUT SHALL change only in DONE and SHALL hold its value otherwise.
REQ-019 BUSY SHALL be 1 in SHIFT and PAR, 0 in IDLE and DONE.
REQ-020 START=1 in SHIFT or PAR SHALL discard the partial frame and restart SHIFT with count 0; START in DONE SHALL be honoured after DONE (LOAD still issued, next state SHIFT).
REQ-021 START and SVALID together in IDLE: START taken, that bit NOT shifted.
REQ-022 Bit count SHALL be 3 bits and never exceed 4.

Reset
REQ-023 RST=1 SHALL immediately force state IDLE, count 0, shift register 0, D_OUT=4'b0000, LOAD=0, BUSY=0, ERR=0, independent of CLK.
REQ-024 RST asserted mid-frame SHALL abort the frame with no LOAD; first frame after release requires a new START.

Configuration
REQ-025 Macro NIBBLE_DESER_PARITY_EN defined: PAR state and ERR logic present per REQ-015.
REQ-026 Macro undefined: PAR state absent, SHIFT goes straight to DONE, ERR tied 0, frame is 4 bits.

Structure
REQ-027 Shared package SHALL hold NIBBLE_W = 4, count width, and the state enum (IDLE, SHIFT, PAR, DONE).
REQ-028 Single module; no sub-module; the FSM and shift register live in one block.

Verification
REQ-029 MSB_FIRST=1, START then bits 1,0,1,1 on consecutive SVALID cycles -> LOAD one cycle later, D_OUT=4'b1011, BUSY low after.
REQ-030 MSB_FIRST=0, same bits -> D_OUT=4'b1101.
REQ-031 SVALID gaps: bits 0,1,1,0 with two idle cycles between each -> D_OUT=4'b0110, single LOAD.
REQ-032 START after 2 bits then 1,1,1,1 -> D_OUT=4'b1111, exactly one LOAD.
REQ-033 PARITY_EN: data 1,0,1,1 parity 0 -> ERR=1, no LOAD, D_OUT keeps previous value; parity 1 -> LOAD, D_OUT=4'b1011.
REQ-034 RST pulsed between edges after 3 bits -> outputs 0 immediately, no LOAD; a following full frame loads normally.
